if_pc_gen: RTL and testbench

- Fetch-stage PC generator and instruction-SRAM request driver.
- Sits in front of the IF/ID register and produces the next fetch address plus the per-instruction sideband: PC+4, PC+8, debug PC, fetch-exception flag and delay-slot flag.
- Resolves exception, ERET, branch and stall redirects with fixed priority.
- Holds a branch redirect that resolves during a stall until the pipe advances.

---
 rtl/if_pc_gen_pkg.sv | 22 ++
 rtl/if_npc_mux.sv | 42 ++++
 rtl/if_pc_gen.sv | 102 ++++++++++
 tb/tb_if_pc_gen.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_pc_gen_pkg.sv
// Shared constants for the fetch PC generator: default reset/exception
// addresses and the redirect select encoding.
package if_pc_gen_pkg;

  localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  // Listed highest priority first.
  typedef enum logic [2:0] {
    SEL_EXC  = 3'd0,
    SEL_ERET = 3'd1,
    SEL_BR   = 3'd2,
    SEL_PEND = 3'd3,
    SEL_HOLD = 3'd4,
    SEL_SEQ  = 3'd5
  } npc_sel_e;

  function automatic logic is_flush_sel(input npc_sel_e sel);
    return (sel == SEL_EXC) || (sel == SEL_ERET);
  endfunction

endpackage

// File: rtl/if_npc_mux.sv
// Fixed-priority next-fetch-address selector: exception, ERET, branch,
// held redirect, stall refetch, then sequential PC+4.
module if_npc_mux
  import if_pc_gen_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = if_pc_gen_pkg::EXC_VECTOR
) (
  input  logic        en_i,
  input  logic        exc_flush_i,
  input  logic        eret_flush_i,
  input  logic [31:0] epc_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        pend_i,
  input  logic [31:0] pend_pc_i,
  input  logic [31:0] pc_i,
  output logic [31:0] npc_o,
  output npc_sel_e    sel_o
);

  always_comb begin
    sel_o = SEL_SEQ;
    npc_o = pc_i + 32'd4;
    if (exc_flush_i) begin
      sel_o = SEL_EXC;
      npc_o = EXC_VEC;
    end else if (eret_flush_i) begin
      sel_o = SEL_ERET;
      npc_o = epc_i;
    end else if (br_taken_i) begin
      sel_o = SEL_BR;
      npc_o = br_target_i;
    end else if (pend_i) begin
      sel_o = SEL_PEND;
      npc_o = pend_pc_i;
    end else if (!en_i) begin
      sel_o = SEL_HOLD;
      npc_o = pc_i;
    end
  end

endmodule

// File: rtl/if_pc_gen.sv
// Fetch-stage PC generator and instruction-SRAM request driver.
// Optional misaligned-fetch detection under IF_PC_ALIGN_CHECK_EN.
module if_pc_gen #(
  parameter logic [31:0] RESET_PC   = if_pc_gen_pkg::RESET_PC,
  parameter logic [31:0] EXC_VECTOR = if_pc_gen_pkg::EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        En,
  input  logic        exc_flush,
  input  logic        eret_flush,
  input  logic [31:0] epc,
  input  logic        br_taken_D,
  input  logic [31:0] br_target_D,
  input  logic        is_branch_D,
  output logic [31:0] N_PC4_D,
  output logic [31:0] N_PC8_D,
  output logic [31:0] N_debug_pc_D,
  output logic        PC_EXC_IF,
  output logic        Delay_Next,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr
);

  import if_pc_gen_pkg::*;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_q, pend_d;
  logic        started_q;
  logic [31:0] npc;
  npc_sel_e    sel;
  logic        flush;
  logic        pc_exc;

  if_npc_mux #(
    .EXC_VEC (EXC_VECTOR)
  ) u_npc_mux (
    .en_i         (En),
    .exc_flush_i  (exc_flush),
    .eret_flush_i (eret_flush),
    .epc_i        (epc),
    .br_taken_i   (br_taken_D),
    .br_target_i  (br_target_D),
    .pend_i       (pend_q),
    .pend_pc_i    (pend_pc_q),
    .pc_i         (pc_q),
    .npc_o        (npc),
    .sel_o        (sel)
  );

  assign flush = is_flush_sel(sel);

  always_comb begin
    pc_d      = (En || flush) ? npc : pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    // A flush outranks a held branch; a stalled taken branch (re)captures its target.
    if (flush) begin
      pend_d = 1'b0;
    end else if (br_taken_D && !En) begin
      pend_d    = 1'b1;
      pend_pc_d = br_target_D;
    end else if (En) begin
      pend_d = 1'b0;
    end
  end

  // pc_q resets one word below RESET_PC so the first sequential fetch lands on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC - 32'd4;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'd0;
      started_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      started_q <= 1'b1;
    end
  end

  // started_q is observation-only state for debug.
  logic unused_started;
  assign unused_started = started_q;

`ifdef IF_PC_ALIGN_CHECK_EN
  assign pc_exc = |npc[1:0];
`else
  assign pc_exc = 1'b0;
`endif

  assign PC_EXC_IF      = pc_exc;
  assign N_debug_pc_D   = npc;
  assign N_PC4_D        = npc + 32'd4;
  assign N_PC8_D        = npc + 32'd8;
  assign inst_sram_addr = npc;
  assign inst_sram_en   = ~rst & (En | flush) & ~pc_exc;
  assign Delay_Next     = is_branch_D & En & ~exc_flush & ~eret_flush;

endmodule

// File: tb/tb_if_pc_gen.sv
// Scenario bench for if_pc_gen: per-cycle expected fetch outputs are queued
// as stimulus is built and popped when the cycle is sampled.
module tb_if_pc_gen;

`ifdef IF_PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst, En, exc_flush, eret_flush, br_taken_D, is_branch_D;
  logic [31:0] epc, br_target_D;
  logic [31:0] N_PC4_D, N_PC8_D, N_debug_pc_D, inst_sram_addr;
  logic        PC_EXC_IF, Delay_Next, inst_sram_en;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        r, en, exc, eret, br, isb;
    logic [31:0] epc, tgt;
  } stim_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        en, dly, exc;
  } exp_t;

  exp_t sb[$];

  if_pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .En             (En),
    .exc_flush      (exc_flush),
    .eret_flush     (eret_flush),
    .epc            (epc),
    .br_taken_D     (br_taken_D),
    .br_target_D    (br_target_D),
    .is_branch_D    (is_branch_D),
    .N_PC4_D        (N_PC4_D),
    .N_PC8_D        (N_PC8_D),
    .N_debug_pc_D   (N_debug_pc_D),
    .PC_EXC_IF      (PC_EXC_IF),
    .Delay_Next     (Delay_Next),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr)
  );

  always #5 clk = ~clk;

  function automatic stim_t S(input logic r, en, exc, eret, br, isb,
                              input logic [31:0] epc_v, tgt_v);
    stim_t s;
    s.r = r; s.en = en; s.exc = exc; s.eret = eret; s.br = br; s.isb = isb;
    s.epc = epc_v; s.tgt = tgt_v;
    return s;
  endfunction

  function automatic exp_t E(input logic [31:0] addr, input logic en, dly, exc);
    exp_t e;
    e.addr = addr; e.en = en; e.dly = dly; e.exc = exc;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.r; En = s.en; exc_flush = s.exc; eret_flush = s.eret;
    br_taken_D = s.br; is_branch_D = s.isb; epc = s.epc; br_target_D = s.tgt;
  endtask

  task automatic test_reset();
    stim_t st[$];
    exp_t  e;
    st.push_back(S(1,1,0,0,0,0,0,0)); sb.push_back(E(RPC, 0,0,0));
    st.push_back(S(1,0,0,0,0,0,0,0)); sb.push_back(E(32'hBFBF_FFFC, 0,0,0));
    st.push_back(S(0,1,0,0,0,0,0,0)); sb.push_back(E(RPC, 1,0,0));
    st.push_back(S(0,1,0,0,0,0,0,0)); sb.push_back(E(32'hBFC0_0004, 1,0,0));
    st.push_back(S(0,1,0,0,0,0,0,0)); sb.push_back(E(32'hBFC0_0008, 1,0,0));
    foreach (st[i]) begin
      @(posedge clk); #1; apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_sram_addr, N_debug_pc_D, N_PC4_D, N_PC8_D, inst_sram_en, Delay_Next, PC_EXC_IF}
          !== {e.addr, e.addr, e.addr + 32'd4, e.addr + 32'd8, e.en, e.dly, e.exc}) begin
        errors++;
        $display("FAIL reset[%0d]: got addr=%h dbg=%h pc4=%h pc8=%h en=%b dly=%b exc=%b; want addr=%h en=%b dly=%b exc=%b",
                 i, inst_sram_addr, N_debug_pc_D, N_PC4_D, N_PC8_D, inst_sram_en, Delay_Next, PC_EXC_IF,
                 e.addr, e.en, e.dly, e.exc);
      end
    end
  endtask

  task automatic test_branch_run();
    stim_t st[$];
    exp_t  e;
    st.push_back(S(0,1,0,0,0,0,0,0));            sb.push_back(E(32'hBFC0_000C, 1,0,0));
    st.push_back(S(0,1,0,0,0,0,0,0));            sb.push_back(E(32'hBFC0_0010, 1,0,0));
    st.push_back(S(0,1,0,0,1,1,0,32'hBFC0_0100)); sb.push_back(E(32'hBFC0_0100, 1,1,0));
    st.push_back(S(0,1,0,0,0,0,0,0));            sb.push_back(E(32'hBFC0_0104, 1,0,0));
    foreach (st[i]) begin
      @(posedge clk); #1; apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_sram_addr, N_debug_pc_D, N_PC4_D, N_PC8_D, inst_sram_en, Delay_Next, PC_EXC_IF}
          !== {e.addr, e.addr, e.addr + 32'd4, e.addr + 32'd8, e.en, e.dly, e.exc}) begin
        errors++;
        $display("FAIL branch_run[%0d]: got addr=%h en=%b dly=%b exc=%b pc8=%h; want addr=%h en=%b dly=%b exc=%b",
                 i, inst_sram_addr, inst_sram_en, Delay_Next, PC_EXC_IF, N_PC8_D, e.addr, e.en, e.dly, e.exc);
      end
    end
  endtask

  task automatic test_branch_stall();
    stim_t st[$];
    exp_t  e;
    // Taken branch while stalled: redirect is held until the pipe advances.
    st.push_back(S(0,0,0,0,1,1,0,32'hBFC0_0200)); sb.push_back(E(32'hBFC0_0200, 0,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0));            sb.push_back(E(32'hBFC0_0200, 0,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0));            sb.push_back(E(32'hBFC0_0200, 0,0,0));
    st.push_back(S(0,1,0,0,0,0,0,0));            sb.push_back(E(32'hBFC0_0200, 1,0,0));
    st.push_back(S(0,1,0,0,0,0,0,0));            sb.push_back(E(32'hBFC0_0204, 1,0,0));
    // Second stalled branch overwrites the held target.
    st.push_back(S(0,0,0,0,1,0,0,32'hBFC0_0300)); sb.push_back(E(32'hBFC0_0300, 0,0,0));
    st.push_back(S(0,0,0,0,1,0,0,32'hBFC0_0400)); sb.push_back(E(32'hBFC0_0400, 0,0,0));
    st.push_back(S(0,0,0,0,0,0,0,0));            sb.push_back(E(32'hBFC0_0400, 0,0,0));
    st.push_back(S(0,1,0,0,0,0,0,0));            sb.push_back(E(32'hBFC0_0400, 1,0,0));
    st.push_back(S(0,1,0,0,0,0,0,0));            sb.push_back(E(32'hBFC0_0404, 1,0,0));
    // Plain stall refetches the last issued address.
    st.push_back(S(0,0,0,0,0,1,0,0));            sb.push_back(E(32'hBFC0_0404, 0,0,0));
    foreach (st[i]) begin
      @(posedge clk); #1; apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_sram_addr, N_debug_pc_D, N_PC4_D, N_PC8_D, inst_sram_en, Delay_Next, PC_EXC_IF}
          !== {e.addr, e.addr, e.addr + 32'd4, e.addr + 32'd8, e.en, e.dly, e.exc}) begin
        errors++;
        $display("FAIL branch_stall[%0d]: got addr=%h en=%b dly=%b exc=%b; want addr=%h en=%b dly=%b exc=%b",
                 i, inst_sram_addr, inst_sram_en, Delay_Next, PC_EXC_IF, e.addr, e.en, e.dly, e.exc);
      end
    end
  endtask

  task automatic test_priority();
    stim_t st[$];
    exp_t  e;
    st.push_back(S(0,0,0,0,1,0,0,32'hBFC0_0500));                       sb.push_back(E(32'hBFC0_0500, 0,0,0));
    st.push_back(S(0,0,1,1,1,1,32'hBFC0_0600,32'hBFC0_0700));           sb.push_back(E(32'hBFC0_0380, 1,0,0));
    st.push_back(S(0,1,0,0,0,0,0,0));                                   sb.push_back(E(32'hBFC0_0384, 1,0,0));
    st.push_back(S(0,1,0,1,1,1,32'hBFC0_0600,32'hBFC0_0700));           sb.push_back(E(32'hBFC0_0600, 1,0,0));
    st.push_back(S(0,0,0,0,1,0,0,32'hBFC0_0800));                       sb.push_back(E(32'hBFC0_0800, 0,0,0));
    st.push_back(S(0,1,0,0,1,1,0,32'hBFC0_0900));                       sb.push_back(E(32'hBFC0_0900, 1,1,0));
    st.push_back(S(0,1,0,0,0,0,0,0));                                   sb.push_back(E(32'hBFC0_0904, 1,0,0));
    foreach (st[i]) begin
      @(posedge clk); #1; apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_sram_addr, N_debug_pc_D, N_PC4_D, N_PC8_D, inst_sram_en, Delay_Next, PC_EXC_IF}
          !== {e.addr, e.addr, e.addr + 32'd4, e.addr + 32'd8, e.en, e.dly, e.exc}) begin
        errors++;
        $display("FAIL priority[%0d]: got addr=%h en=%b dly=%b exc=%b; want addr=%h en=%b dly=%b exc=%b",
                 i, inst_sram_addr, inst_sram_en, Delay_Next, PC_EXC_IF, e.addr, e.en, e.dly, e.exc);
      end
    end
  endtask

  task automatic test_eret_align_wrap();
    stim_t st[$];
    exp_t  e;
    st.push_back(S(0,1,0,1,0,0,32'h8000_1234,0)); sb.push_back(E(32'h8000_1234, 1,0,0));
    st.push_back(S(0,1,0,1,0,0,32'h8000_1236,0)); sb.push_back(E(32'h8000_1236, !ALIGN,0,ALIGN));
    st.push_back(S(0,1,0,0,0,0,0,0));             sb.push_back(E(32'h8000_123A, !ALIGN,0,ALIGN));
    st.push_back(S(0,1,0,1,0,0,32'hFFFF_FFFC,0)); sb.push_back(E(32'hFFFF_FFFC, 1,0,0));
    st.push_back(S(0,1,0,0,0,0,0,0));             sb.push_back(E(32'h0000_0000, 1,0,0));
    foreach (st[i]) begin
      @(posedge clk); #1; apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_sram_addr, N_debug_pc_D, N_PC4_D, N_PC8_D, inst_sram_en, Delay_Next, PC_EXC_IF}
          !== {e.addr, e.addr, e.addr + 32'd4, e.addr + 32'd8, e.en, e.dly, e.exc}) begin
        errors++;
        $display("FAIL eret_align_wrap[%0d]: got addr=%h pc4=%h pc8=%h en=%b exc=%b; want addr=%h en=%b exc=%b",
                 i, inst_sram_addr, N_PC4_D, N_PC8_D, inst_sram_en, PC_EXC_IF, e.addr, e.en, e.exc);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t st[$];
    exp_t  e;
    st.push_back(S(0,0,0,0,1,0,0,32'hBFC0_0A00)); sb.push_back(E(32'hBFC0_0A00, 0,0,0));
    st.push_back(S(1,0,0,0,0,0,0,0));            sb.push_back(E(32'hBFBF_FFFC, 0,0,0));
    st.push_back(S(0,1,0,0,0,0,0,0));            sb.push_back(E(RPC, 1,0,0));
    st.push_back(S(0,1,0,0,0,0,0,0));            sb.push_back(E(32'hBFC0_0004, 1,0,0));
    foreach (st[i]) begin
      @(posedge clk); #1; apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_sram_addr, N_debug_pc_D, N_PC4_D, N_PC8_D, inst_sram_en, Delay_Next, PC_EXC_IF}
          !== {e.addr, e.addr, e.addr + 32'd4, e.addr + 32'd8, e.en, e.dly, e.exc}) begin
        errors++;
        $display("FAIL reset_mid_stall[%0d]: got addr=%h en=%b dly=%b exc=%b; want addr=%h en=%b dly=%b exc=%b",
                 i, inst_sram_addr, inst_sram_en, Delay_Next, PC_EXC_IF, e.addr, e.en, e.dly, e.exc);
      end
    end
  endtask

  initial begin
    apply(S(1,0,0,0,0,0,0,0));
    test_reset();
    test_branch_run();
    test_branch_stall();
    test_priority();
    test_eret_align_wrap();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
